reset_vector_fetch: RTL and testbench

- Consumer of the synchronized reset from the power-on reset generator.
- After reset deasserts, runs the 6502-style reset sequence: a fixed dummy-cycle delay, then a fetch of the 16-bit reset vector over a simple read handshake.
- Loads PC and SP, then asserts cpu_run to release the CPU core.
- Sits between the reset generator and the core's fetch unit, sharing the memory read port through the arbiter.

---
 rtl/reset_vector_fetch.sv | 169 ++++++++++++++++
 tb/tb_reset_vector_fetch.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/reset_vector_fetch.sv
// rtl/reset_vector_fetch.sv - 6502-style reset sequencer: delay, optional stack dummy reads, vector fetch
// Optional feature macro: RESET_STACK_DUMMY_EN (three dummy stack reads before the vector fetch)
module reset_vector_fetch #(
  parameter logic [15:0] VECTOR_ADDR  = 16'hFFFC,
  parameter int unsigned DELAY_CYCLES = 4,
  parameter logic [7:0]  SP_INIT      = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  rd_data,
  output logic [15:0] pc,
  output logic [7:0]  sp,
  output logic        cpu_run
);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_DELAY  = 3'd1;
`ifdef RESET_STACK_DUMMY_EN
  localparam logic [2:0] S_STACK  = 3'd2;
`endif
  localparam logic [2:0] S_VEC_LO = 3'd3;
  localparam logic [2:0] S_VEC_HI = 3'd4;
  localparam logic [2:0] S_RUN    = 3'd5;

  localparam int unsigned         CNT_W          = (DELAY_CYCLES < 1) ? 1 : $clog2(DELAY_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST       = CNT_W'(DELAY_CYCLES);
  localparam logic [15:0]         VECTOR_ADDR_HI = VECTOR_ADDR + 16'd1;
`ifndef RESET_STACK_DUMMY_EN
  localparam logic [7:0]          SP_FINAL       = SP_INIT - 8'd3;
`endif

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      pc_q, pc_d;
  logic [7:0]       sp_q, sp_d;
  logic             mem_req_q, mem_req_d;
  logic [15:0]      mem_addr_q, mem_addr_d;
  logic             cpu_run_q, cpu_run_d;
  logic             xfer;
`ifdef RESET_STACK_DUMMY_EN
  logic [1:0]       stk_q, stk_d;
`endif

  // Acks only count against a request that is actually on the bus.
  assign xfer = mem_req_q & mem_ack;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
`ifdef RESET_STACK_DUMMY_EN
    stk_d   = stk_q;
`endif
    case (state_q)
      S_RESET: begin
        state_d = S_DELAY;
        cnt_d   = '0;
      end
      S_DELAY: begin
        // DELAY occupies DELAY_CYCLES+1 cycles, so a zero delay still spends one cycle here.
        if (cnt_q == CNT_LAST) begin
`ifdef RESET_STACK_DUMMY_EN
          state_d = S_STACK;
          stk_d   = 2'd0;
`else
          state_d = S_VEC_LO;
          sp_d    = SP_FINAL;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef RESET_STACK_DUMMY_EN
      S_STACK: begin
        if (xfer) begin
          sp_d = sp_q - 8'd1;
          if (stk_q == 2'd2) begin
            state_d = S_VEC_LO;
          end else begin
            stk_d = stk_q + 2'd1;
          end
        end
      end
`endif
      S_VEC_LO: begin
        if (xfer) begin
          pc_d[7:0] = rd_data;
          state_d   = S_VEC_HI;
        end
      end
      S_VEC_HI: begin
        if (xfer) begin
          pc_d[15:8] = rd_data;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  // Bus outputs are registered from the next state so they are glitch-free and stable per state.
  always_comb begin
    mem_req_d  = 1'b0;
    mem_addr_d = 16'h0000;
    cpu_run_d  = (state_d == S_RUN);
    case (state_d)
`ifdef RESET_STACK_DUMMY_EN
      S_STACK: begin
        mem_req_d  = 1'b1;
        mem_addr_d = {8'h01, sp_d};
      end
`endif
      S_VEC_LO: begin
        mem_req_d  = 1'b1;
        mem_addr_d = VECTOR_ADDR;
      end
      S_VEC_HI: begin
        mem_req_d  = 1'b1;
        mem_addr_d = VECTOR_ADDR_HI;
      end
      default: begin
        mem_req_d  = 1'b0;
        mem_addr_d = 16'h0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_RESET;
      cnt_q      <= '0;
      pc_q       <= 16'h0000;
      sp_q       <= SP_INIT;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 16'h0000;
      cpu_run_q  <= 1'b0;
`ifdef RESET_STACK_DUMMY_EN
      stk_q      <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      sp_q       <= sp_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      cpu_run_q  <= cpu_run_d;
`ifdef RESET_STACK_DUMMY_EN
      stk_q      <= stk_d;
`endif
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign pc       = pc_q;
  assign sp       = sp_q;
  assign cpu_run  = cpu_run_q;

endmodule

// File: tb/tb_reset_vector_fetch.sv
// tb/tb_reset_vector_fetch.sv - randomized bench for reset_vector_fetch against a request-list reference model
module tb_reset_vector_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;

  int          sel = 0;
  logic        drv_rn = 1'b0;
  logic        drv_ack = 1'b0;
  logic [7:0]  drv_data = 8'h00;

  logic        a_rn, a_ack, a_req, a_run;
  logic [15:0] a_addr, a_pc;
  logic [7:0]  a_sp;
  logic        b_rn, b_ack, b_req, b_run;
  logic [15:0] b_addr, b_pc;
  logic [7:0]  b_sp;

  logic        o_req, o_run;
  logic [15:0] o_addr, o_pc;
  logic [7:0]  o_sp;

  // Unselected instance is held in reset.
  assign a_rn  = (sel == 0) ? drv_rn  : 1'b0;
  assign a_ack = (sel == 0) ? drv_ack : 1'b0;
  assign b_rn  = (sel == 1) ? drv_rn  : 1'b0;
  assign b_ack = (sel == 1) ? drv_ack : 1'b0;

  assign o_req  = (sel == 0) ? a_req  : b_req;
  assign o_run  = (sel == 0) ? a_run  : b_run;
  assign o_addr = (sel == 0) ? a_addr : b_addr;
  assign o_pc   = (sel == 0) ? a_pc   : b_pc;
  assign o_sp   = (sel == 0) ? a_sp   : b_sp;

  reset_vector_fetch u_dut_a (
    .clk      (clk),
    .reset_n  (a_rn),
    .mem_req  (a_req),
    .mem_addr (a_addr),
    .mem_ack  (a_ack),
    .rd_data  (drv_data),
    .pc       (a_pc),
    .sp       (a_sp),
    .cpu_run  (a_run)
  );

  reset_vector_fetch #(
    .VECTOR_ADDR  (16'hFFFF),
    .DELAY_CYCLES (0),
    .SP_INIT      (8'h02)
  ) u_dut_b (
    .clk      (clk),
    .reset_n  (b_rn),
    .mem_req  (b_req),
    .mem_addr (b_addr),
    .mem_ack  (b_ack),
    .rd_data  (drv_data),
    .pc       (b_pc),
    .sp       (b_sp),
    .cpu_run  (b_run)
  );

  // Model parameters for the selected instance plus the vector bytes held in memory.
  logic [15:0] m_va;
  int          m_d;
  logic [7:0]  m_sp;
  logic [7:0]  lo, hi;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [15:0] addr);
    logic [15:0] va1;
    va1 = m_va + 16'd1;
    if (addr == m_va) return lo;
    if (addr == va1)  return hi;
    return 8'($urandom);
  endfunction

  task automatic run_seq(input int ack_pct, input bit spur, input bit abort_hi, input int fixed_wait);
    logic [15:0] expq[$];
    int          edges, waits, hold_cnt, nbus;
    bit          done, first_req, prev_req, prev_ack, ack;
    logic [15:0] prev_addr;
    logic [7:0]  exp_sp;
    edges = 0; waits = 0; hold_cnt = 0;
    done = 0; first_req = 1; prev_req = 0; prev_ack = 0; prev_addr = 16'h0;
    exp_sp = m_sp - 8'd3;
`ifdef RESET_STACK_DUMMY_EN
    for (int i = 0; i < 3; i++) expq.push_back({8'h01, 8'(m_sp - 8'(i))});
`endif
    expq.push_back(m_va);
    expq.push_back(m_va + 16'd1);
    nbus = expq.size();

    @(negedge clk);
    drv_rn = 1'b0; drv_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_req",  o_req,  0);
    check_eq("rst_addr", o_addr, 0);
    check_eq("rst_pc",   o_pc,   0);
    check_eq("rst_sp",   o_sp,   m_sp);
    check_eq("rst_run",  o_run,  0);
    drv_rn = 1'b1;

    while (!done && edges < 400) begin
      @(negedge clk);
      edges++;
      if (o_run) begin
        check_eq("latency", edges - 1, 1 + m_d + nbus + waits);
        check_eq("pc", o_pc, {hi, lo});
        check_eq("sp", o_sp, exp_sp);
        check_eq("all_reqs_done", expq.size(), 0);
        check_eq("req_in_run", o_req, 0);
        for (int k = 0; k < 4; k++) begin
          drv_ack = spur ? 1'($urandom_range(1)) : 1'b0;
          drv_data = 8'($urandom);
          @(negedge clk);
          check_eq("run_held", o_run, 1);
          check_eq("pc_held", o_pc, {hi, lo});
          check_eq("idle_req", o_req, 0);
        end
        drv_ack = 1'b0;
        done = 1;
      end else if (o_req) begin
        if (first_req) begin
          check_eq("first_req_edge", edges - 1, 1 + m_d);
          first_req = 0;
        end
        if (prev_req && !prev_ack) check_eq("addr_hold", o_addr, prev_addr);
        check_eq("req_expected", expq.size() > 0, 1);
        if (expq.size() > 0) check_eq("req_addr", o_addr, expq[0]);
        if (abort_hi && expq.size() == 1) begin
          check_eq("pc_lo_latched", o_pc[7:0], lo);
          drv_rn = 1'b0; drv_ack = 1'b0;
          @(negedge clk);
          check_eq("abort_req", o_req, 0);
          check_eq("abort_pc", o_pc, 0);
          check_eq("abort_run", o_run, 0);
          check_eq("abort_sp", o_sp, m_sp);
          return;
        end
        if (fixed_wait > 0 && o_addr == m_va) hold_cnt++;
        if (fixed_wait > 0 && o_addr == m_va && hold_cnt <= fixed_wait) ack = 0;
        else ack = ($urandom_range(99) < ack_pct);
        if (ack && fixed_wait > 0 && o_addr == m_va) check_eq("hold_cycles", hold_cnt, fixed_wait + 1);
        drv_ack = ack;
        drv_data = ack ? byte_at(o_addr) : 8'($urandom);
        if (ack && expq.size() > 0) void'(expq.pop_front());
        if (!ack) waits++;
        prev_req = 1; prev_ack = ack; prev_addr = o_addr;
      end else begin
        if (prev_req && !prev_ack) check_eq("req_dropped", o_req, 1);
        drv_ack = spur ? 1'($urandom_range(1)) : 1'b0;
        drv_data = 8'($urandom);
        prev_req = 0; prev_ack = 0;
      end
    end
    if (!done) check_eq("timeout", 1, 0);
  endtask

  initial begin
    sel = 0; m_va = 16'hFFFC; m_d = 4; m_sp = 8'h00;
    lo = 8'h34; hi = 8'h12;
    run_seq(100, 0, 0, 0);
    lo = 8'($urandom); hi = 8'($urandom);
    run_seq(100, 0, 0, 3);
    run_seq(100, 0, 1, 0);
    run_seq(100, 0, 0, 0);
    for (int r = 0; r < 4; r++) begin
      lo = 8'($urandom); hi = 8'($urandom);
      run_seq(50, 1, 0, 0);
    end

    sel = 1; m_va = 16'hFFFF; m_d = 0; m_sp = 8'h02;
    lo = 8'hCD; hi = 8'hAB;
    run_seq(100, 1, 0, 0);
    for (int r = 0; r < 3; r++) begin
      lo = 8'($urandom); hi = 8'($urandom);
      run_seq(60, 1, 0, 0);
    end
    run_seq(100, 1, 1, 0);
    run_seq(70, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
